// File: rtl/ysyx_22050518_mul_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle into a 2*XLEN+4 bit accumulator.
// Supports unsigned, signed x unsigned and signed x signed modes, plus a shortened 32-bit word mode.
module ysyx_22050518_mul_iter #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned EARLY_W = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic            flush,
   input  logic            mulw,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] multiplicand,
   input  logic [XLEN-1:0] multiplier,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_hi,
   output logic [XLEN-1:0] result_lo
);

   localparam int unsigned OP_W    = XLEN + 2;
   localparam int unsigned ACC_W   = 2 * XLEN + 4;
   localparam int unsigned STEPS   = XLEN / 2 + 1;
   localparam int unsigned W_STEPS = 17;
   localparam int unsigned CNT_W   = $clog2(STEPS);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q;
   logic             ready_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] mcand_q;
   logic [OP_W:0]    mplier_q;
   logic             word_q;
   logic             zero_q;

   logic [OP_W-1:0]  a_ext;
   logic [OP_W-1:0]  b_ext;
   logic [ACC_W-1:0] pp;
   logic             unused_acc;

   // Operand extension: A is signed if bit1, B only for the 11 encoding.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      if (mulw) begin
         a_ext = OP_W'($signed(multiplicand[31:0]));
         b_ext = OP_W'($signed(multiplier[31:0]));
      end else begin
         if (mul_signed[1]) begin
            a_ext = OP_W'($signed(multiplicand));
         end else begin
            a_ext = OP_W'(multiplicand);
         end
         if (&mul_signed) begin
            b_ext = OP_W'($signed(multiplier));
         end else begin
            b_ext = OP_W'(multiplier);
         end
      end
   end

   // Booth digit from the low three bits of the (pre-shifted) multiplier.
   always_comb begin
      pp = '0;
      unique case (mplier_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         word_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (flush) begin
         state_q <= StIdle;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (mul_valid && ready_q) begin
                  state_q  <= StBusy;
                  ready_q  <= 1'b0;
                  acc_q    <= '0;
                  mcand_q  <= ACC_W'($signed(a_ext));
                  mplier_q <= {b_ext, 1'b0};
                  word_q   <= mulw;
                  zero_q   <= (mul_signed == 2'b01);
                  if (mulw && (EARLY_W != 0)) begin
                     cnt_q <= CNT_W'(W_STEPS - 1);
                  end else begin
                     cnt_q <= CNT_W'(STEPS - 1);
                  end
               end
            end
            StBusy: begin
               acc_q    <= acc_q + pp;
               mcand_q  <= mcand_q << 2;
               mplier_q <= {{2{mplier_q[OP_W]}}, mplier_q[OP_W:2]};
               if (cnt_q == '0) begin
                  state_q <= StDone;
                  valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mul_ready = ready_q;
   assign out_valid = valid_q;

   // Guard bits above 2*XLEN only absorb Booth sign carries.
   assign unused_acc = ^acc_q[ACC_W-1:2*XLEN];

   always_comb begin
      result_hi = '0;
      result_lo = '0;
      if (valid_q && !zero_q) begin
         if (word_q) begin
            result_lo = XLEN'($signed(acc_q[31:0]));
         end else begin
            result_hi = acc_q[2*XLEN-1:XLEN];
            result_lo = acc_q[XLEN-1:0];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050518_mul_iter.sv
// Directed bench for ysyx_22050518_mul_iter at XLEN=64, EARLY_W=1: products, latency, flush,
// back-pressure and asynchronous reset.
module tb_ysyx_22050518_mul_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_valid;
   logic        mul_ready;
   logic        flush;
   logic        mulw;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand;
   logic [63:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result_hi;
   logic [63:0] result_lo;

   int unsigned n_vec;
   int unsigned n_err;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

   ysyx_22050518_mul_iter #(
      .XLEN    (64),
      .EARLY_W (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mul_valid    (mul_valid),
      .mul_ready    (mul_ready),
      .flush        (flush),
      .mulw         (mulw),
      .mul_signed   (mul_signed),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result_hi    (result_hi),
      .result_lo    (result_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake on the next edge, then scramble inputs to prove they are latched.
   task automatic issue(input logic w, input logic [1:0] s, input logic [63:0] a,
                        input logic [63:0] b);
      int guard;
      guard = 0;
      while (!mul_ready && guard < 100) begin
         tick();
         guard++;
      end
      check("issue_ready", 64'(mul_ready), 64'd1);
      mul_valid    = 1'b1;
      mulw         = w;
      mul_signed   = s;
      multiplicand = a;
      multiplier   = b;
      tick();
      mul_valid    = 1'b0;
      mulw         = 1'($urandom);
      mul_signed   = 2'($urandom);
      multiplicand = {$urandom, $urandom};
      multiplier   = {$urandom, $urandom};
   endtask

   // Latency is counted in cycles from the handshake cycle t.
   task automatic expect_res(input string tag, input int lat, input logic [63:0] hi,
                             input logic [63:0] lo);
      int n;
      n = 1;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_hi"}, result_hi, hi);
      check({tag, "_lo"}, result_lo, lo);
      check({tag, "_rdy"}, 64'(mul_ready), 64'd0);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      check({tag, "_cvalid"}, 64'(out_valid), 64'd0);
      check({tag, "_cready"}, 64'(mul_ready), 64'd1);
      check({tag, "_clo"}, result_lo, 64'd0);
   endtask

   task automatic run_vec(input string tag, input logic w, input logic [1:0] s,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] hi,
                          input logic [63:0] lo, input int lat);
      issue(w, s, a, b);
      expect_res(tag, lat, hi, lo);
      consume(tag);
   endtask

   task automatic watch_idle(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (out_valid || !mul_ready) seen = 1'b1;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      n_vec        = 0;
      n_err        = 0;
      rst          = 1'b1;
      mul_valid    = 1'b0;
      flush        = 1'b0;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = '0;
      multiplier   = '0;
      out_ready    = 1'b1;

      #2;
      check("rst_ready", 64'(mul_ready), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_hi", result_hi, 64'd0);
      check("rst_lo", result_lo, 64'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1 check("rel_ready_pre", 64'(mul_ready), 64'd0);
      tick();
      check("rel_ready_post", 64'(mul_ready), 64'd1);

      run_vec("u_ones", 1'b0, 2'b00, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34);
      run_vec("su_ones", 1'b0, 2'b10, ONES, ONES, ONES, 64'd1, 34);
      run_vec("ss_ones", 1'b0, 2'b11, ONES, ONES, 64'd0, 64'd1, 34);
      run_vec("w_max2", 1'b1, 2'b00, 64'h1234_5678_7FFF_FFFF, 64'hABCD_0000_0000_0002,
              64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 18);
      run_vec("w_neg", 1'b1, 2'b11, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000,
              64'd0, 64'hFFFF_FFFF_8000_0000, 18);
      run_vec("rsv01", 1'b0, 2'b01, 64'd5, 64'd7, 64'd0, 64'd0, 34);
      run_vec("ss_minmin", 1'b0, 2'b11, MINN, MINN, 64'h4000_0000_0000_0000, 64'd0, 34);
      run_vec("su_minmin", 1'b0, 2'b10, MINN, MINN, 64'hC000_0000_0000_0000, 64'd0, 34);
      run_vec("u_min2", 1'b0, 2'b00, MINN, 64'd2, 64'd1, 64'd0, 34);
      run_vec("ss_m3x5", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, ONES,
              64'hFFFF_FFFF_FFFF_FFF1, 34);

      // Flush in BUSY cycle 10 alongside a new request.
      issue(1'b0, 2'b00, 64'd3, 64'd5);
      repeat (9) tick();
      flush        = 1'b1;
      mul_valid    = 1'b1;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = 64'd7;
      multiplier   = 64'd9;
      tick();
      check("flush_ready", 64'(mul_ready), 64'd1);
      check("flush_valid", 64'(out_valid), 64'd0);
      flush     = 1'b0;
      mul_valid = 1'b0;
      watch_idle("flush_busy_quiet", 40);

      // Flush in IDLE blocks acceptance.
      flush     = 1'b1;
      mul_valid = 1'b1;
      tick();
      flush     = 1'b0;
      mul_valid = 1'b0;
      watch_idle("flush_idle_quiet", 40);

      // Back-pressure: result held steady while out_ready is low.
      out_ready = 1'b0;
      issue(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
      expect_res("bp", 34, ONES, 64'hFFFF_FFFF_FFFF_FFF1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_hi", result_hi, ONES);
         check("bp_hold_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFF1);
         check("bp_hold_rdy", 64'(mul_ready), 64'd0);
      end
      consume("bp");

      // Asynchronous reset while DONE.
      out_ready = 1'b0;
      issue(1'b0, 2'b00, 64'd3, 64'd5);
      expect_res("rd", 34, 64'd0, 64'd15);
      #2 rst = 1'b1;
      #1;
      check("rd_valid", 64'(out_valid), 64'd0);
      check("rd_lo", result_lo, 64'd0);
      check("rd_ready", 64'(mul_ready), 64'd0);
      tick();
      check("rd_hold_ready", 64'(mul_ready), 64'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      check("rd_rel_ready", 64'(mul_ready), 64'd1);

      // Asynchronous reset mid-BUSY, then a fresh 3x5.
      issue(1'b0, 2'b00, ONES, ONES);
      repeat (5) tick();
      #2 rst = 1'b1;
      #1;
      check("rb_valid", 64'(out_valid), 64'd0);
      check("rb_ready", 64'(mul_ready), 64'd0);
      check("rb_hi", result_hi, 64'd0);
      check("rb_lo", result_lo, 64'd0);
      rst = 1'b0;
      tick();
      check("rb_rel_ready", 64'(mul_ready), 64'd1);
      run_vec("rb_3x5", 1'b0, 2'b00, 64'd3, 64'd5, 64'd0, 64'd15, 34);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
